io_responder: RTL and testbench

- CPU-side I/O peripheral. It answers the RD/WR port strobes and the active-low nSIG[7:0] signal strobes that the instruction control decoder produces.
- Buffers CPU writes into a TX FIFO that drains to an external device through a valid/ready handshake.
- Buffers device bytes into an RX FIFO that the CPU pops with RD.
- Returns a status bit on the carry path, for conditional jumps.

---
 rtl/io_responder.sv | 184 ++++++++++++++++++
 tb/tb_io_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_responder.sv
// io_responder: CPU port/strobe responder with TX and RX byte FIFOs.
// Optional sticky TX overflow flag: define IO_OVERFLOW_FLAG_EN.
module io_responder #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RD,
  input  logic       WR,
  input  logic [7:0] nSIG,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       flag,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic [7:0] sig_q, sig_d;
  logic       rd_edge, wr_edge;
  logic [7:0] sig_edge;

  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    tx_mem_d [DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d;
  logic [AW-1:0] tx_rp_q, tx_rp_d;
  logic [AW:0]   tx_cnt_q, tx_cnt_d;
  logic          tx_full, tx_push, tx_pop;

  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    rx_mem_d [DEPTH];
  logic [AW-1:0] rx_wp_q, rx_wp_d;
  logic [AW-1:0] rx_rp_q, rx_rp_d;
  logic [AW:0]   rx_cnt_q, rx_cnt_d;
  logic          rx_nempty, rx_push, rx_pop;

  logic [7:0] rdata_q, rdata_d;
  logic       flag_q, flag_d;

`ifdef IO_OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d;
  logic unused_sig;
  assign unused_sig = sig_edge[7];
`else
  logic unused_sig;
  assign unused_sig = ^sig_edge[7:5];
`endif

  assign tx_data   = tx_mem_q[tx_rp_q];
  assign tx_valid  = (tx_cnt_q != '0);
  assign rx_ready  = (rx_cnt_q != FULL);
  assign rdata     = rdata_q;
  assign flag      = flag_q;
  assign tx_full   = (tx_cnt_q == FULL);
  assign rx_nempty = (rx_cnt_q != '0);

  // Strobe history and first-cycle edge detection
  always_comb begin
    rd_d     = RD;
    wr_d     = WR;
    sig_d    = ~nSIG;
    rd_edge  = RD & ~rd_q;
    wr_edge  = WR & ~wr_q;
    sig_edge = ~nSIG & ~sig_q;
  end

  // TX FIFO: WR pushes, device drains; a same-cycle pop frees a full slot
  always_comb begin
    tx_pop   = tx_valid & tx_ready;
    tx_push  = wr_edge & (~tx_full | tx_pop);
    tx_mem_d = tx_mem_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    if (sig_edge[0]) begin
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      tx_cnt_d = '0;
    end else begin
      if (tx_push) begin
        tx_mem_d[tx_wp_q] = wdata;
        tx_wp_d = tx_wp_q + AW'(1);
      end
      if (tx_pop) tx_rp_d = tx_rp_q + AW'(1);
      tx_cnt_d = tx_cnt_q + (AW+1)'(tx_push)
               - (AW+1)'(tx_pop);
    end
  end

  // RX FIFO: device fills against registered rx_ready, RD pops into rdata
  always_comb begin
    rx_push  = rx_valid & rx_ready;
    rx_pop   = rd_edge & rx_nempty;
    rx_mem_d = rx_mem_q;
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    rdata_d  = rdata_q;
    if (rd_edge) rdata_d = rx_pop ? rx_mem_q[rx_rp_q] : 8'h00;
    if (sig_edge[1]) begin
      rx_wp_d  = '0;
      rx_rp_d  = '0;
      rx_cnt_d = '0;
    end else begin
      if (rx_push) begin
        rx_mem_d[rx_wp_q] = rx_data;
        rx_wp_d = rx_wp_q + AW'(1);
      end
      if (rx_pop) rx_rp_d = rx_rp_q + AW'(1);
      rx_cnt_d = rx_cnt_q + (AW+1)'(rx_push)
               - (AW+1)'(rx_pop);
    end
  end

  // Status flag loads from pre-update FIFO state, highest strobe wins
  always_comb begin
    flag_d = flag_q;
    if (sig_edge[4]) flag_d = 1'b0;
`ifdef IO_OVERFLOW_FLAG_EN
    else if (sig_edge[5]) flag_d = ovf_q;
`endif
    else if (sig_edge[3]) flag_d = ~tx_full;
    else if (sig_edge[2]) flag_d = rx_nempty;
  end

`ifdef IO_OVERFLOW_FLAG_EN
  // Sticky overflow: a write edge against a full TX sets it, set beats clear
  always_comb begin
    ovf_d = ovf_q;
    if (sig_edge[6]) ovf_d = 1'b0;
    if (wr_edge && tx_full) ovf_d = 1'b1;
  end
`endif

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      sig_q    <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      rdata_q  <= 8'h00;
      flag_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
`ifdef IO_OVERFLOW_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      sig_q    <= sig_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      rdata_q  <= rdata_d;
      flag_q   <= flag_d;
      tx_mem_q <= tx_mem_d;
      rx_mem_q <= rx_mem_d;
`ifdef IO_OVERFLOW_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed checks of io_responder FIFOs, strobes and flag.
// Overflow-flag steps run when IO_OVERFLOW_FLAG_EN is defined.
module tb_io_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       RD, WR;
  logic [7:0] nSIG, wdata, rdata;
  logic       flag;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;

  int checks = 0;
  int errors = 0;

  io_responder #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .RD(RD), .WR(WR),
    .nSIG(nSIG), .wdata(wdata), .rdata(rdata),
    .flag(flag), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int i);
    nSIG = 8'hFF;
    nSIG[i] = 1'b0;
    step();
    nSIG = 8'hFF;
    step();
  endtask

  task automatic wr_byte(input logic [7:0] b);
    WR = 1'b1;
    wdata = b;
    step();
    WR = 1'b0;
    step();
  endtask

  task automatic rd_pulse();
    RD = 1'b1;
    step();
    RD = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0] exp_q [4];
    rst = 1'b1; RD = 1'b0; WR = 1'b0;
    nSIG = 8'hFF; wdata = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_tx_valid", 8'(tx_valid), 8'h00);
    check("rst_rx_ready", 8'(rx_ready), 8'h01);
    check("rst_rdata", rdata, 8'h00);
    check("rst_flag", 8'(flag), 8'h00);
    pulse(2);
    check("idle_sig2", 8'(flag), 8'h00);

    // TX fill, fifth write dropped
    wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
    wr_byte(8'h44); wr_byte(8'h55);
    check("txf_valid", 8'(tx_valid), 8'h01);
    check("txf_head", tx_data, 8'h11);
    pulse(3);
    check("txf_sig3", 8'(flag), 8'h00);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_v", 8'(tx_valid), 8'h01);
      check("drain_d", tx_data, exp_q[i]);
      step();
    end
    check("drain_empty", 8'(tx_valid), 8'h00);
    tx_ready = 1'b0;
    pulse(3);
    check("tx_empty_sig3", 8'(flag), 8'h01);
    pulse(4);
    check("sig4_clr", 8'(flag), 8'h00);

    // WR held three cycles pushes once
    WR = 1'b1; wdata = 8'hA5;
    step(); step(); step();
    WR = 1'b0;
    step();
    check("hold_v", 8'(tx_valid), 8'h01);
    check("hold_d", tx_data, 8'hA5);
    tx_ready = 1'b1;
    step();
    check("hold_one", 8'(tx_valid), 8'h00);
    tx_ready = 1'b0;

    // RX path
    rx_valid = 1'b1; rx_data = 8'h7E; step();
    rx_data = 8'h81; step();
    rx_valid = 1'b0;
    pulse(2);
    check("rx_sig2_ne", 8'(flag), 8'h01);
    rd_pulse(); check("rd_7e", rdata, 8'h7E);
    rd_pulse(); check("rd_81", rdata, 8'h81);
    rd_pulse(); check("rd_empty", rdata, 8'h00);
    pulse(2);
    check("rx_sig2_e", 8'(flag), 8'h00);

    // TX full: WR edge coincides with pop
    wr_byte(8'h01); wr_byte(8'h02);
    wr_byte(8'h03); wr_byte(8'h04);
    tx_ready = 1'b1; WR = 1'b1; wdata = 8'h66;
    step();
    WR = 1'b0; tx_ready = 1'b0;
    step();
    pulse(3);
    check("conc_full", 8'(flag), 8'h00);
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h66};
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("conc_d", tx_data, exp_q[i]);
      step();
    end
    check("conc_empty", 8'(tx_valid), 8'h00);
    tx_ready = 1'b0;

    // RX full: RD pop does not admit a push that cycle
    rx_valid = 1'b1;
    rx_data = 8'h10; step();
    rx_data = 8'h20; step();
    rx_data = 8'h30; step();
    rx_data = 8'h40; step();
    check("rxf_rdy", 8'(rx_ready), 8'h00);
    rx_data = 8'h50; RD = 1'b1;
    step();
    check("rxc_rdata", rdata, 8'h10);
    check("rxc_rdy", 8'(rx_ready), 8'h01);
    RD = 1'b0;
    step();
    check("rxc_push", 8'(rx_ready), 8'h00);
    rx_valid = 1'b0;
    exp_q = '{8'h20, 8'h30, 8'h40, 8'h50};
    for (int i = 0; i < 4; i++) begin
      rd_pulse();
      check("rxc_pop", rdata, exp_q[i]);
    end
    rd_pulse();
    check("rxc_last", rdata, 8'h00);

    // Flush TX together with a WR edge
    wr_byte(8'h77);
    nSIG = 8'hFE; WR = 1'b1; wdata = 8'h88;
    step();
    nSIG = 8'hFF; WR = 1'b0;
    step();
    check("flush_tx", 8'(tx_valid), 8'h00);

    // Flush RX
    rx_valid = 1'b1; rx_data = 8'h5A; step();
    rx_valid = 1'b0;
    pulse(1);
    pulse(3);
    check("pre_frx", 8'(flag), 8'h01);
    pulse(2);
    check("flush_rx", 8'(flag), 8'h00);

    // Reset during RX handshake with RX half full
    rx_valid = 1'b1;
    rx_data = 8'h99; step();
    rx_data = 8'hAA; step();
    rx_data = 8'hBB; step();
    rx_valid = 1'b0;
    rd_pulse();
    check("pre_rst_rd", rdata, 8'h99);
    wr_byte(8'hCC);
    pulse(3);
    check("pre_rst_flag", 8'(flag), 8'h01);
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'hDD;
    step();
    rst = 1'b0; rx_valid = 1'b0;
    check("rst2_tx_valid", 8'(tx_valid), 8'h00);
    check("rst2_rx_ready", 8'(rx_ready), 8'h01);
    check("rst2_rdata", rdata, 8'h00);
    check("rst2_flag", 8'(flag), 8'h00);
    pulse(3);
    pulse(2);
    check("rst2_rx_empty", 8'(flag), 8'h00);

`ifdef IO_OVERFLOW_FLAG_EN
    pulse(4);
    wr_byte(8'h01); wr_byte(8'h02);
    wr_byte(8'h03); wr_byte(8'h04);
    wr_byte(8'h55);
    pulse(5);
    check("ovf_set", 8'(flag), 8'h01);
    pulse(6);
    pulse(5);
    check("ovf_clr", 8'(flag), 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
